vec_issue_ctrl: RTL and testbench

Operand sequencer and result collector for the 16-lane x 32-bit vector math unit. Holds the four 512-bit vector registers A1..A4 and accepts one command at a time. Drives A1/A2 and the 2-bit instruction into the math unit, then captures the unit's A3 (high halves) and A4 (low halves) outputs back into the register file. Sits between the top-level controller/memory loader and the combinational math unit.

---
 rtl/vec_issue_ctrl.sv | 137 +++++++++++++
 tb/tb_vec_issue_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_issue_ctrl.sv
// Operand sequencer and result collector for the LANES x 32-bit vector math unit.
// Optional completed-op counter enabled by defining VEC_ISSUE_PERF_CNT_EN.
module vec_issue_ctrl #(
  parameter int LANES         = 16,
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic                  ld_en,
  input  logic [1:0]            ld_addr,
  input  logic [32*LANES-1:0]   ld_data,
  input  logic [1:0]            rd_addr,
  output logic [32*LANES-1:0]   rd_data,
  output logic [32*LANES-1:0]   mu_a1,
  output logic [32*LANES-1:0]   mu_a2,
  output logic [1:0]            mu_instr,
  input  logic [32*LANES-1:0]   mu_a3,
  input  logic [32*LANES-1:0]   mu_a4,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [CNT_W-1:0]      op_count
);

  localparam int VW = 32 * LANES;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_WB
  } state_e;

  state_e          state_q;
  logic [VW-1:0]   regs_q [4];
  logic [VW-1:0]   mu_a1_q;
  logic [VW-1:0]   mu_a2_q;
  logic [1:0]      mu_instr_q;
  logic [3:0]      settle_q;
  logic            illegal_q;
  logic            done_q;
  logic            err_q;

  wire cmd_legal = (cmd_op == 2'b01) || (cmd_op == 2'b10);

  // NOTE: every register below is sequential state, so it is written only with
  // non-blocking assignments; this keeps all readers seeing pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mu_a1_q    <= '0;
      mu_a2_q    <= '0;
      mu_instr_q <= 2'b00;
      settle_q   <= '0;
      illegal_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      // NOTE: the register file is only four entries and must read back as zero
      // after reset, so it is cleared here rather than left to power-up state.
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (ld_en) begin
            regs_q[ld_addr] <= ld_data;
          end else if (cmd_valid) begin
            state_q    <= ST_ISSUE;
            mu_a1_q    <= regs_q[0];
            mu_a2_q    <= regs_q[1];
            mu_instr_q <= cmd_legal ? cmd_op : 2'b00;
            illegal_q  <= !cmd_legal;
          end
        end
        ST_ISSUE: begin
          settle_q <= 4'(SETTLE_CYCLES - 1);
          // A single settle cycle is covered by ISSUE itself, so WAIT is skipped.
          if (SETTLE_CYCLES == 1) begin
            state_q <= ST_WB;
            done_q  <= 1'b1;
            err_q   <= illegal_q;
          end else begin
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          settle_q <= settle_q - 4'd1;
          if (settle_q == 4'd1) begin
            state_q <= ST_WB;
            done_q  <= 1'b1;
            err_q   <= illegal_q;
          end
        end
        ST_WB: begin
          if (!illegal_q) begin
            regs_q[2] <= mu_a3;
            regs_q[3] <= mu_a4;
          end
          mu_instr_q <= 2'b00;
          state_q    <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef VEC_ISSUE_PERF_CNT_EN
  logic [CNT_W-1:0] op_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      op_cnt_q <= '0;
    end else if (state_q == ST_WB && !illegal_q) begin
      op_cnt_q <= op_cnt_q + CNT_W'(1);
    end
  end

  assign op_count = op_cnt_q;
`else
  assign op_count = '0;
`endif

  assign busy      = (state_q != ST_IDLE);
  assign cmd_ready = (state_q == ST_IDLE) && !ld_en;
  assign rd_data   = regs_q[rd_addr];
  assign mu_a1     = mu_a1_q;
  assign mu_a2     = mu_a2_q;
  assign mu_instr  = mu_instr_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_vec_issue_ctrl.sv
// Scoreboard bench for vec_issue_ctrl: two instances (SETTLE_CYCLES 1 and 3) share
// stimulus; op_count expectations follow VEC_ISSUE_PERF_CNT_EN.
module tb_vec_issue_ctrl;

  localparam int LANES = 16;
  localparam int VW    = 32 * LANES;
  localparam int CW    = 3;
  localparam int S0    = 1;
  localparam int S1    = 3;

  typedef struct {
    logic [1:0]    instr;
    logic          err;
    logic [VW-1:0] a1;
    logic [VW-1:0] a2;
    int            t_done;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_w [2];
  logic          cmd_valid;
  logic [1:0]    cmd_op;
  logic          ld_en;
  logic [1:0]    ld_addr;
  logic [VW-1:0] ld_data;
  logic [1:0]    rd_addr;

  logic          cmd_ready_w [2];
  logic          busy_w [2];
  logic          done_w [2];
  logic          err_w [2];
  logic [1:0]    mu_instr_w [2];
  logic [CW-1:0] op_count_w [2];
  logic [VW-1:0] rd_data_w [2];
  logic [VW-1:0] mu_a1_w [2];
  logic [VW-1:0] mu_a2_w [2];
  logic [VW-1:0] mu_a3_w [2];
  logic [VW-1:0] mu_a4_w [2];

  int            checks   = 0;
  int            failures = 0;
  int            cyc      = 0;
  exp_t          sb [2][$];
  logic [VW-1:0] mreg [2][4];
  int            cnt_m [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in math unit: mul gives the 64-bit unsigned product split high/low,
  // sum gives all-ones high and the 32-bit lane sum low, 00 gives junk.
  function automatic logic [2*VW-1:0] math(input logic [1:0] ins,
                                           input logic [VW-1:0] a, input logic [VW-1:0] b);
    logic [VW-1:0] hi;
    logic [VW-1:0] lo;
    logic [63:0]   p;
    hi = '0;
    lo = '0;
    for (int l = 0; l < LANES; l++) begin
      p = {32'd0, a[l*32+:32]} * {32'd0, b[l*32+:32]};
      case (ins)
        2'b01:   begin hi[l*32+:32] = p[63:32];      lo[l*32+:32] = p[31:0]; end
        2'b10:   begin hi[l*32+:32] = 32'hFFFF_FFFF; lo[l*32+:32] = a[l*32+:32] + b[l*32+:32]; end
        default: begin hi[l*32+:32] = 32'hBAD0_0000 + l; lo[l*32+:32] = ~a[l*32+:32]; end
      endcase
    end
    return {hi, lo};
  endfunction

  assign {mu_a3_w[0], mu_a4_w[0]} = math(mu_instr_w[0], mu_a1_w[0], mu_a2_w[0]);
  assign {mu_a3_w[1], mu_a4_w[1]} = math(mu_instr_w[1], mu_a1_w[1], mu_a2_w[1]);

  vec_issue_ctrl #(.LANES(LANES), .SETTLE_CYCLES(S0), .CNT_W(CW)) u_dut_s1 (
    .clk(clk), .rst(rst_w[0]), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_w[0]),
    .cmd_op(cmd_op), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .rd_addr(rd_addr), .rd_data(rd_data_w[0]), .mu_a1(mu_a1_w[0]), .mu_a2(mu_a2_w[0]),
    .mu_instr(mu_instr_w[0]), .mu_a3(mu_a3_w[0]), .mu_a4(mu_a4_w[0]), .busy(busy_w[0]),
    .done(done_w[0]), .err(err_w[0]), .op_count(op_count_w[0])
  );

  vec_issue_ctrl #(.LANES(LANES), .SETTLE_CYCLES(S1), .CNT_W(CW)) u_dut_s3 (
    .clk(clk), .rst(rst_w[1]), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_w[1]),
    .cmd_op(cmd_op), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .rd_addr(rd_addr), .rd_data(rd_data_w[1]), .mu_a1(mu_a1_w[1]), .mu_a2(mu_a2_w[1]),
    .mu_instr(mu_instr_w[1]), .mu_a3(mu_a3_w[1]), .mu_a4(mu_a4_w[1]), .busy(busy_w[1]),
    .done(done_w[1]), .err(err_w[1]), .op_count(op_count_w[1])
  );

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [VW-1:0] splat(input logic [31:0] x);
    logic [VW-1:0] v;
    for (int l = 0; l < LANES; l++) v[l*32+:32] = x;
    return v;
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int l = 0; l < LANES; l++) v[l*32+:32] = $urandom;
    return v;
  endfunction

  // Monitor: samples 2 ns after the falling edge, compares against the queue head.
  always @(negedge clk) begin
    #2;
    for (int i = 0; i < 2; i++) begin
      if (!rst_w[i]) begin
        if (busy_w[i]) begin
          if (sb[i].size() == 0) begin
            checks++;
            failures++;
            $display("FAIL busy_no_cmd[%0d]: busy with no command outstanding", i);
          end else begin
            check($sformatf("mu_a1[%0d]", i), mu_a1_w[i], sb[i][0].a1);
            check($sformatf("mu_a2[%0d]", i), mu_a2_w[i], sb[i][0].a2);
            check($sformatf("mu_instr[%0d]", i), VW'(mu_instr_w[i]), VW'(sb[i][0].instr));
          end
          check($sformatf("ready_busy[%0d]", i), VW'(cmd_ready_w[i]), VW'(0));
        end else begin
          check($sformatf("mu_instr_idle[%0d]", i), VW'(mu_instr_w[i]), VW'(0));
          check($sformatf("ready_idle[%0d]", i), VW'(cmd_ready_w[i]), VW'(!ld_en));
        end
        if (sb[i].size() > 0 && cyc == sb[i][0].t_done) begin
          check($sformatf("done[%0d]@%0d", i, cyc), VW'(done_w[i]), VW'(1));
          check($sformatf("err[%0d]@%0d", i, cyc), VW'(err_w[i]), VW'(sb[i][0].err));
          void'(sb[i].pop_front());
        end else begin
          check($sformatf("done_idle[%0d]@%0d", i, cyc), VW'(done_w[i]), VW'(0));
          check($sformatf("err_idle[%0d]@%0d", i, cyc), VW'(err_w[i]), VW'(0));
        end
      end
    end
  end

  task automatic do_reset();
    rst_w[0] = 1'b1;
    rst_w[1] = 1'b1;
    repeat (2) @(negedge clk);
    rst_w[0] = 1'b0;
    rst_w[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      for (int r = 0; r < 4; r++) mreg[i][r] = '0;
      cnt_m[i] = 0;
      sb[i].delete();
    end
  endtask

  task automatic check_regs();
    for (int r = 0; r < 4; r++) begin
      rd_addr = 2'(r);
      #1;
      for (int i = 0; i < 2; i++)
        check($sformatf("reg%0d[%0d]", r, i), rd_data_w[i], mreg[i][r]);
    end
    for (int i = 0; i < 2; i++) begin
`ifdef VEC_ISSUE_PERF_CNT_EN
      check($sformatf("op_count[%0d]", i), VW'(op_count_w[i]), VW'(cnt_m[i]));
`else
      check($sformatf("op_count[%0d]", i), VW'(op_count_w[i]), VW'(0));
`endif
    end
    @(negedge clk);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 40; k++) begin
      if (!busy_w[0] && !busy_w[1]) break;
      @(negedge clk);
    end
    check("idle_timeout", VW'(busy_w[0] || busy_w[1]), VW'(0));
  endtask

  task automatic load(input logic [1:0] a, input logic [VW-1:0] d);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    for (int i = 0; i < 2; i++) mreg[i][a] = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // Called at a falling edge with both instances idle; the command is accepted
  // at the next rising edge, so cycle T is the current cycle count.
  task automatic push_cmd(input logic [1:0] op);
    exp_t e;
    bit   legal;
    legal = (op == 2'b01) || (op == 2'b10);
    for (int i = 0; i < 2; i++) begin
      e.instr  = legal ? op : 2'b00;
      e.err    = !legal;
      e.a1     = mreg[i][0];
      e.a2     = mreg[i][1];
      e.t_done = cyc + 1 + ((i == 0) ? S0 : S1);
      sb[i].push_back(e);
      if (legal) begin
        {mreg[i][2], mreg[i][3]} = math(op, mreg[i][0], mreg[i][1]);
        cnt_m[i] = (cnt_m[i] + 1) % (1 << CW);
      end
    end
  endtask

  task automatic issue(input logic [1:0] op, input bit with_ld, input bit busy_ld);
    logic [VW-1:0] v;
    cmd_op    = op;
    cmd_valid = 1'b1;
    if (with_ld) begin
      v       = rand_vec();
      ld_en   = 1'b1;
      ld_addr = 2'd0;
      ld_data = v;
      #1;
      for (int i = 0; i < 2; i++) begin
        check($sformatf("ready_ld_collide[%0d]", i), VW'(cmd_ready_w[i]), VW'(0));
        mreg[i][0] = v;
      end
      @(negedge clk);
      ld_en = 1'b0;
    end
    push_cmd(op);
    @(negedge clk);
    cmd_valid = 1'b0;
    if (busy_ld) begin
      ld_en   = 1'b1;
      ld_addr = 2'd2;
      ld_data = rand_vec();
      @(negedge clk);
      ld_en = 1'b0;
    end
    wait_idle();
    check_regs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_w[0]  = 1'b1;
    rst_w[1]  = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    ld_en     = 1'b0;
    ld_addr   = 2'd0;
    ld_data   = '0;
    rd_addr   = 2'd0;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_busy[%0d]", i), VW'(busy_w[i]), VW'(0));
      check($sformatf("rst_ready[%0d]", i), VW'(cmd_ready_w[i]), VW'(1));
      check($sformatf("rst_mu_a1[%0d]", i), mu_a1_w[i], '0);
    end
    check_regs();

    // Directed: sum of 5 and -3, then mul, illegal ops, load/command collision.
    load(2'd0, splat(32'd5));
    load(2'd1, splat(32'hFFFF_FFFD));
    issue(2'b10, 1'b0, 1'b0);
    issue(2'b01, 1'b0, 1'b0);
    issue(2'b11, 1'b0, 1'b0);
    issue(2'b00, 1'b0, 1'b1);
    issue(2'b01, 1'b1, 1'b0);
    issue(2'b10, 1'b1, 1'b1);

    for (int n = 0; n < 12; n++) begin
      if ($urandom_range(0, 1) == 1) load(2'd0, rand_vec());
      if ($urandom_range(0, 1) == 1) load(2'd1, rand_vec());
      if ($urandom_range(0, 3) == 0) load(2'($urandom_range(2, 3)), rand_vec());
      issue(2'($urandom_range(0, 3)), $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
    end

    // Reset only the SETTLE=3 instance while it sits in WAIT.
    load(2'd0, rand_vec());
    load(2'd1, rand_vec());
    cmd_op    = 2'b01;
    cmd_valid = 1'b1;
    push_cmd(2'b01);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    rst_w[1] = 1'b1;
    @(negedge clk);
    rst_w[1] = 1'b0;
    sb[1].delete();
    for (int r = 0; r < 4; r++) mreg[1][r] = '0;
    cnt_m[1] = 0;
    check("midop_rst_busy", VW'(busy_w[1]), VW'(0));
    check("midop_rst_ready", VW'(cmd_ready_w[1]), VW'(1));
    wait_idle();
    check_regs();
    repeat (3) @(negedge clk);

    // Counter: three legal and one illegal, then enough to wrap the 3-bit count.
    do_reset();
    issue(2'b01, 1'b0, 1'b0);
    issue(2'b11, 1'b0, 1'b0);
    issue(2'b10, 1'b0, 1'b0);
    issue(2'b01, 1'b0, 1'b0);
    for (int n = 0; n < 6; n++) issue(2'b10, 1'b0, 1'b0);
    repeat (3) @(negedge clk);

    for (int i = 0; i < 2; i++)
      check($sformatf("sb_drained[%0d]", i), VW'(sb[i].size()), VW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
